cache_lu_arb: RTL and testbench
===============================

Name: cache_lu_arb

Overview:
Schedules the single cache pipe lookup slot (q1) between the core request path and TQ entries whose merge buffer is fill-ready. Uses a round-robin grant among fill-ready entries and a starvation counter that forces a fill slot after a run of core wins. The grant is zero-cycle and combinational. Arbitration state is registered. Sits between the TQ entry array and the pipe q1 mux, and drives the core stall.

Parameters:
NUM_TQ_ENTRY, 8, number of TQ entries; power of 2, at least 2.
STARVE_MAX, 4, consecutive core grants allowed while a fill is pending before a fill slot is forced; range 1..15.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
core_req_valid  in  1  core request present; must be held stable while core_stall=1.
tq_free_exists  in  1  at least one TQ entry is S_IDLE.
fill_ready  in  NUM_TQ_ENTRY  per-entry flag; entry is in S_MB_FILL_READY.
pipe_hold  in  1  pipe cannot accept a q1 lookup this cycle.
core_grant  out  1  core request owns q1 this cycle.
fill_grant  out  NUM_TQ_ENTRY  one-hot; this entry's fill owns q1 this cycle.
fill_grant_id  out  log2(NUM_TQ_ENTRY)  encoded fill_grant; 0 when no fill grant.
lu_valid_q1  out  1  core_grant OR any fill_grant bit.
core_stall  out  1  core_req_valid AND NOT core_grant.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_CORE_PRI, starve_cnt=0, rr_ptr=0.
  - While in reset: core_grant=0, fill_grant=0, fill_grant_id=0, lu_valid_q1=0, core_stall=core_req_valid.
- Definitions:
  - fill_pend = OR of fill_ready.
  - core_ok = core_req_valid AND tq_free_exists.
- pipe_hold=1: no grants. core_stall=core_req_valid. State, starve_cnt and rr_ptr are unchanged.
- Round-robin selection:
  - Search fill_ready starting at index rr_ptr, upward, wrapping at NUM_TQ_ENTRY-1 to 0. The first set bit is the winner k.
  - On a fill grant, rr_ptr <= (k+1) mod NUM_TQ_ENTRY.
  - rr_ptr is unchanged on any other cycle.
- S_CORE_PRI:
  - If core_ok: core_grant=1.
    - If fill_pend: starve_cnt++. When starve_cnt reaches STARVE_MAX, next state is S_FILL_FORCE and starve_cnt saturates.
    - Otherwise starve_cnt <= 0.
  - Else if fill_pend: fill winner granted, starve_cnt <= 0. This covers the core stalled because tq_free_exists=0.
  - Else: no grant, starve_cnt <= 0.
- S_FILL_FORCE:
  - If fill_pend: fill winner granted, core not granted, starve_cnt <= 0, next state S_CORE_PRI.
  - If fill_pend=0 (fills withdrawn): behave exactly as S_CORE_PRI this cycle, starve_cnt <= 0, next state S_CORE_PRI.
- Grant exclusivity: core_grant and fill_grant are never both nonzero. fill_grant is always zero or one-hot.
- fill_ready is sampled in the same cycle as the grant. The granted entry leaves S_MB_FILL_READY on the next edge; the block keeps no memory of it.
- Reset asserted mid-operation: all state clears immediately; pending inputs are re-arbitrated from rr_ptr=0 after release.
- STARVE_MAX=1: every core grant made while a fill is pending is followed by a forced fill slot.

Optional Feature:
CACHE_LU_ARB_PERF_EN:
- With the macro defined: adds three 32-bit saturating counters, each exposed as an output port and reset to 0:
  - perf_core_grants: counts cycles with core_grant=1.
  - perf_fill_grants: counts cycles with any fill_grant bit set.
  - perf_core_stall_cycles: counts cycles with core_stall=1.
- Without the macro: the counters and their ports are absent; arbitration behaviour is identical.

Decomposition:
- cache_param_pkg gains:
  - STARVE_MAX default.
  - t_arb_state enum {S_CORE_PRI, S_FILL_FORCE}.
  - t_starve_cnt (4 bits).
  - Reuse of existing NUM_TQ_ENTRY and t_tq_id.
- Sub-module cache_rr_arb, parameterised by width N:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded id, any-request.
  - Implementation: rotate, find-first, rotate back.
  - Purely combinational, reusable by future FM request arbitration.

Test Plan:
1. Reset release, core_req_valid=1, tq_free_exists=1, fill_ready=0 -> core_grant=1 every cycle, starve_cnt stays 0, core_stall=0.
2. Continuous core_ok, fill_ready=8'b0000_0100, STARVE_MAX=4 -> 4 core grants, then fill_grant=8'b0000_0100 with fill_grant_id=2 and core_stall=1 for 1 cycle, then core again; rr_ptr=3 after.
3. core_req_valid=0, fill_ready=8'b1000_0001 held for 3 cycles -> grants id 0, 7, 0; rr_ptr sequence 1, 0, 1 (wrap-around).
4. core_req_valid=1, tq_free_exists=0, fill_ready=8'b0001_0000 -> fill_grant id 4, core_stall=1, starve_cnt=0.
5. pipe_hold=1 while in S_FILL_FORCE with fills pending -> no grants, core_stall=1; after pipe_hold=0 the forced fill is issued first.
6. rst pulsed low mid-sequence with rr_ptr=5 and state S_FILL_FORCE -> outputs drop to 0 asynchronously; after release, fill_ready=8'b0010_0001 with no core -> grants id 0 first.

Source files
------------

// File: rtl/cache_lu_arb_pkg.sv
// Shared types and defaults for the cache lookup-slot arbiter.
package cache_lu_arb_pkg;

  localparam int DEF_NUM_TQ_ENTRY = 8;
  localparam int DEF_STARVE_MAX   = 4;
  localparam int TQ_ID_W          = $clog2(DEF_NUM_TQ_ENTRY);

  typedef logic [TQ_ID_W-1:0] t_tq_id;
  typedef logic [3:0]         t_starve_cnt;

  typedef enum logic {
    S_CORE_PRI,
    S_FILL_FORCE
  } t_arb_state;

endpackage

// File: rtl/cache_lu_arb_if.sv
// q1 lookup-slot request/grant bundle between TQ/core side and the arbiter.
interface cache_lu_arb_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         core_req_valid;
  logic         tq_free_exists;
  logic [N-1:0] fill_ready;
  logic         pipe_hold;
  logic         core_grant;
  logic [N-1:0] fill_grant;
  logic [W-1:0] fill_grant_id;
  logic         lu_valid_q1;
  logic         core_stall;

  modport master (
    output core_req_valid, tq_free_exists, fill_ready, pipe_hold,
    input  core_grant, fill_grant, fill_grant_id, lu_valid_q1, core_stall
  );

  modport slave (
    input  core_req_valid, tq_free_exists, fill_ready, pipe_hold,
    output core_grant, fill_grant, fill_grant_id, lu_valid_q1, core_stall
  );

endinterface

// File: rtl/cache_lu_arb_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module cache_rr_arb #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] id,
  output logic                 any
);
  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // rot[0] is the request at ptr; N is a power of 2 so W-bit adds wrap mod N
  for (genvar i = 0; i < N; i++) begin : g_rot
    assign rot[i] = req[W'(i) + ptr];
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = W'(i);
  end

  assign any   = |req;
  assign id    = any ? off + ptr : '0;
  assign grant = any ? (N'(1) << id) : '0;

endmodule

// File: rtl/cache_lu_arb.sv
// q1 lookup-slot arbiter: core priority with round-robin fills and starvation forcing.
// Optional CACHE_LU_ARB_PERF_EN adds saturating grant/stall counters.
module cache_lu_arb
  import cache_lu_arb_pkg::*;
#(
  parameter int NUM_TQ_ENTRY = DEF_NUM_TQ_ENTRY,
  parameter int STARVE_MAX   = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  cache_lu_arb_if.slave bus
`ifdef CACHE_LU_ARB_PERF_EN
  ,
  output logic [31:0]   perf_core_grants,
  output logic [31:0]   perf_fill_grants,
  output logic [31:0]   perf_core_stall_cycles
`endif
);
  localparam int IDW = $clog2(NUM_TQ_ENTRY);

  t_arb_state              state;
  t_starve_cnt             starve_cnt;
  t_starve_cnt             cnt_inc;
  logic [IDW-1:0]          rr_ptr;
  logic [NUM_TQ_ENTRY-1:0] rr_grant;
  logic [IDW-1:0]          rr_id;
  logic                    fill_pend;
  logic                    core_ok, active, force_fill, do_core, do_fill, stall;

  cache_rr_arb #(.N(NUM_TQ_ENTRY)) u_rr (
    .req   (bus.fill_ready),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .id    (rr_id),
    .any   (fill_pend)
  );

  // Reset level gates the grants directly so they drop without waiting for a clock
  assign core_ok    = bus.core_req_valid & bus.tq_free_exists;
  assign active     = rst & ~bus.pipe_hold;
  assign force_fill = (state == S_FILL_FORCE) & fill_pend;
  assign do_core    = active & core_ok & ~force_fill;
  assign do_fill    = active & fill_pend & ~do_core;
  assign stall      = bus.core_req_valid & ~do_core;
  assign cnt_inc    = starve_cnt + t_starve_cnt'(1);

  assign bus.core_grant    = do_core;
  assign bus.fill_grant    = do_fill ? rr_grant : '0;
  assign bus.fill_grant_id = do_fill ? rr_id : '0;
  assign bus.lu_valid_q1   = do_core | do_fill;
  assign bus.core_stall    = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_CORE_PRI;
      starve_cnt <= '0;
      rr_ptr     <= '0;
    end else if (!bus.pipe_hold) begin
      if (do_fill) rr_ptr <= rr_id + IDW'(1);
      if (state == S_CORE_PRI && core_ok && fill_pend) begin
        if (cnt_inc >= t_starve_cnt'(STARVE_MAX)) begin
          state      <= S_FILL_FORCE;
          starve_cnt <= t_starve_cnt'(STARVE_MAX);
        end else begin
          starve_cnt <= cnt_inc;
        end
      end else begin
        // Covers the forced slot and the withdrawn-fill case alike
        state      <= S_CORE_PRI;
        starve_cnt <= '0;
      end
    end
  end

`ifdef CACHE_LU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_core_grants       <= '0;
      perf_fill_grants       <= '0;
      perf_core_stall_cycles <= '0;
    end else begin
      if (do_core && perf_core_grants != '1)       perf_core_grants       <= perf_core_grants + 32'd1;
      if (do_fill && perf_fill_grants != '1)       perf_fill_grants       <= perf_fill_grants + 32'd1;
      if (stall && perf_core_stall_cycles != '1)   perf_core_stall_cycles <= perf_core_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_lu_arb.sv
// Directed table-driven bench for cache_lu_arb plus reset and STARVE_MAX=1 sequences.
module tb_cache_lu_arb;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_lu_arb_if #(.N(N)) bus  ();
  cache_lu_arb_if #(.N(N)) bus1 ();

`ifdef CACHE_LU_ARB_PERF_EN
  logic [31:0] pcg0, pfg0, pcs0, pcg1, pfg1, pcs1;
`endif

  cache_lu_arb #(.NUM_TQ_ENTRY(N), .STARVE_MAX(4)) dut (
    .clk (clk), .rst (rst), .bus (bus)
`ifdef CACHE_LU_ARB_PERF_EN
    , .perf_core_grants (pcg0), .perf_fill_grants (pfg0), .perf_core_stall_cycles (pcs0)
`endif
  );

  cache_lu_arb #(.NUM_TQ_ENTRY(N), .STARVE_MAX(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
`ifdef CACHE_LU_ARB_PERF_EN
    , .perf_core_grants (pcg1), .perf_fill_grants (pfg1), .perf_core_stall_cycles (pcs1)
`endif
  );

  typedef struct {
    logic         crv, tf, ph;
    logic [N-1:0] fr;
    logic         cg;
    logic [N-1:0] fg;
    logic [2:0]   id;
    logic         stall;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic crv, tf, ph, input logic [N-1:0] fr,
                              input logic cg, input logic [N-1:0] fg,
                              input logic [2:0] id, input logic stall);
    vec_t v;
    v.crv = crv; v.tf = tf; v.ph = ph; v.fr = fr;
    v.cg = cg; v.fg = fg; v.id = id; v.stall = stall;
    tbl.push_back(v);
  endfunction

  function automatic logic [13:0] exp_of(input vec_t v);
    return {v.cg, v.fg, v.id, v.cg | (|v.fg), v.stall};
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got{cg,fg,id,lu,stall}=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.core_req_valid = v.crv;
    bus.tq_free_exists = v.tf;
    bus.pipe_hold      = v.ph;
    bus.fill_ready     = v.fr;
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1 check(nm, {bus.core_grant, bus.fill_grant, bus.fill_grant_id, bus.lu_valid_q1, bus.core_stall},
             exp_of(v));
  endtask

  task automatic apply1(input vec_t v, input string nm);
    @(negedge clk);
    bus1.core_req_valid = v.crv;
    bus1.tq_free_exists = v.tf;
    bus1.pipe_hold      = v.ph;
    bus1.fill_ready     = v.fr;
    #1 check(nm, {bus1.core_grant, bus1.fill_grant, bus1.fill_grant_id, bus1.lu_valid_q1, bus1.core_stall},
             exp_of(v));
  endtask

  initial begin
    vec_t v;
    // core only, then idle with pipe_hold and nothing pending
    repeat (2) add(1,1,0,8'h00, 1,8'h00,3'd0,0);
    add(1,1,1,8'h00, 0,8'h00,3'd0,1);
    add(0,1,0,8'h00, 0,8'h00,3'd0,0);
    // two fills, rr wrap: 0, 7, 0
    add(0,1,0,8'h81, 0,8'h01,3'd0,0);
    add(0,1,0,8'h81, 0,8'h80,3'd7,0);
    add(0,1,0,8'h81, 0,8'h01,3'd0,0);
    // starvation: 4 core grants then one forced fill (rr 1 -> 3)
    repeat (4) add(1,1,0,8'h04, 1,8'h00,3'd0,0);
    add(1,1,0,8'h04, 0,8'h04,3'd2,1);
    add(1,1,0,8'h00, 1,8'h00,3'd0,0);
    // core blocked on no free TQ entry: fill takes the slot (rr 3 -> 5)
    add(1,0,0,8'h10, 0,8'h10,3'd4,1);
    // reach S_FILL_FORCE, hold the pipe, then forced fill first (rr 5 wraps to 3)
    repeat (4) add(1,1,0,8'h08, 1,8'h00,3'd0,0);
    repeat (2) add(1,1,1,8'h08, 0,8'h00,3'd0,1);
    add(1,1,0,8'h08, 0,8'h08,3'd3,1);
    // fills withdrawn in S_FILL_FORCE: core granted and the run count restarts
    repeat (4) add(1,1,0,8'h10, 1,8'h00,3'd0,0);
    add(1,1,0,8'h00, 1,8'h00,3'd0,0);
    repeat (4) add(1,1,0,8'h10, 1,8'h00,3'd0,0);
    add(1,1,0,8'h10, 0,8'h10,3'd4,1);
    // leave the arbiter in S_FILL_FORCE with rr_ptr=5
    repeat (4) add(1,1,0,8'h20, 1,8'h00,3'd0,0);

    v = '{crv:1, tf:1, ph:0, fr:8'h00, cg:0, fg:8'h00, id:3'd0, stall:1};
    bus1.core_req_valid = 0; bus1.tq_free_exists = 0; bus1.pipe_hold = 0; bus1.fill_ready = '0;
    rst = 1'b0;
    drive(v);
    #2 check("reset_state", {bus.core_grant, bus.fill_grant, bus.fill_grant_id, bus.lu_valid_q1, bus.core_stall},
             exp_of(v));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset mid-operation: forced fill would otherwise be granted here
    @(negedge clk);
    v = '{crv:1, tf:1, ph:0, fr:8'h20, cg:0, fg:8'h00, id:3'd0, stall:1};
    drive(v);
    #1 rst = 1'b0;
    #1 check("mid_reset", {bus.core_grant, bus.fill_grant, bus.fill_grant_id, bus.lu_valid_q1, bus.core_stall},
             exp_of(v));
    @(negedge clk);
    rst = 1'b1;
    apply('{crv:1, tf:1, ph:0, fr:8'h21, cg:1, fg:8'h00, id:3'd0, stall:0}, "post_rst_core");
    apply('{crv:0, tf:1, ph:0, fr:8'h21, cg:0, fg:8'h01, id:3'd0, stall:0}, "post_rst_fill0");
    apply('{crv:0, tf:1, ph:0, fr:8'h21, cg:0, fg:8'h20, id:3'd5, stall:0}, "post_rst_fill5");

    // STARVE_MAX=1: every core grant with a pending fill is followed by a fill slot
    apply1('{crv:1, tf:1, ph:0, fr:8'h02, cg:1, fg:8'h00, id:3'd0, stall:0}, "sm1_core_a");
    apply1('{crv:1, tf:1, ph:0, fr:8'h02, cg:0, fg:8'h02, id:3'd1, stall:1}, "sm1_fill_a");
    apply1('{crv:1, tf:1, ph:0, fr:8'h02, cg:1, fg:8'h00, id:3'd0, stall:0}, "sm1_core_b");
    apply1('{crv:1, tf:1, ph:0, fr:8'h02, cg:0, fg:8'h02, id:3'd1, stall:1}, "sm1_fill_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
